// File: rtl/seg7_scan_ndig.sv
// seg7_scan_ndig: time-multiplexed NDIG-digit common-anode 7-segment driver
//   Adds a double-buffered load, leading-zero blanking and a one-cycle dead time per digit slot.
//   Optional build macro SEG7_DIM_EN adds a 4-bit brightness input that gates the enable duty.
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   digits[4*NDIG-1:0]  hex nibbles, digit 0 least significant
//   dp_in[NDIG-1:0]     decimal points, 1 = lit
//   load                strobe: capture digits/dp_in into the pending buffer
//   blank_lz            1 = suppress leading zeros
//   segments[6:0]       {a..g}, active-low, registered
//   dp                  decimal point, active-low, registered
//   ndig_en[NDIG-1:0]   digit enables, active-low, one-cold or all-high
//   frame               one-cycle pulse when the scan wraps to digit 0
//   brightness[3:0]     duty level 0..15 (SEG7_DIM_EN only)
module seg7_scan_ndig #(
   parameter int NDIG     = 4,
   parameter int DIV_BITS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4*NDIG-1:0] digits,
   input  logic [NDIG-1:0]   dp_in,
   input  logic              load,
   input  logic              blank_lz,
`ifdef SEG7_DIM_EN
   input  logic [3:0]        brightness,
`endif
   output logic [6:0]        segments,
   output logic              dp,
   output logic [NDIG-1:0]   ndig_en,
   output logic              frame
);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   // Hex font packed with glyph 0 in the low bits; 0 = segment lit.
   localparam logic [16*7-1:0] FONT = {
      7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
      7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
      7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
      7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001};

   logic [DIV_BITS-1:0] presc_q, presc_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [4*NDIG-1:0]   pend_q, pend_d, act_q, act_d;
   logic [NDIG-1:0]     pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
   logic                pend_valid_q, pend_valid_d;
   logic                blank_q, blank_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [NDIG-1:0]     en_q, en_d;
   logic                frame_q, frame_d;
   logic                tick, wrap, refresh, on, zero_run;
   logic [NDIG-1:0]     lz;
   logic [3:0]          nib;
`ifdef SEG7_DIM_EN
   logic [3:0]          bright_q, bright_d;
`endif

   always_comb begin
      tick         = &presc_q;
      wrap         = tick && (idx_q == IW'(NDIG-1));
      presc_d      = presc_q + 1'b1;
      idx_d        = tick ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
      pend_d       = load ? digits : pend_q;
      pend_dp_d    = load ? dp_in : pend_dp_q;
      // A load on the wrap tick lands in pending only; the older pending still promotes.
      pend_valid_d = load | (pend_valid_q & ~wrap);
      act_d        = (wrap && pend_valid_q) ? pend_q : act_q;
      act_dp_d     = (wrap && pend_valid_q) ? pend_dp_q : act_dp_q;
      blank_d      = tick ? blank_lz : blank_q;
      // lz[i]: digit i and every digit above it are zero (digit 0 never qualifies).
      zero_run     = 1'b1;
      lz           = '0;
      for (int i = NDIG-1; i >= 0; i--) begin
         zero_run = zero_run && (act_d[4*i +: 4] == 4'h0);
         lz[i]    = zero_run && (i != 0);
      end
      nib          = act_d[4*idx_d +: 4];
      // Reload at slot start and again at presc==1 so the first slot after reset is driven too.
      refresh      = presc_d <= DIV_BITS'(1);
      seg_d        = refresh ? ((blank_d && lz[idx_d]) ? 7'h7F : FONT[7*nib +: 7]) : seg_q;
      dp_d         = refresh ? ~act_dp_d[idx_d] : dp_q;
      on           = presc_d != '0;
`ifdef SEG7_DIM_EN
      bright_d     = tick ? brightness : bright_q;
      on           = on && (presc_d[DIV_BITS-1 -: 4] < bright_d);
`endif
      en_d         = on ? ~(NDIG'(1) << idx_d) : '1;
      frame_d      = wrap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q      <= '0;
         idx_q        <= '0;
         pend_q       <= '0;
         pend_dp_q    <= '0;
         act_q        <= '0;
         act_dp_q     <= '0;
         pend_valid_q <= 1'b0;
         blank_q      <= 1'b0;
         seg_q        <= 7'h7F;
         dp_q         <= 1'b1;
         en_q         <= '1;
         frame_q      <= 1'b0;
`ifdef SEG7_DIM_EN
         bright_q     <= '0;
`endif
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         pend_q       <= pend_d;
         pend_dp_q    <= pend_dp_d;
         act_q        <= act_d;
         act_dp_q     <= act_dp_d;
         pend_valid_q <= pend_valid_d;
         blank_q      <= blank_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         en_q         <= en_d;
         frame_q      <= frame_d;
`ifdef SEG7_DIM_EN
         bright_q     <= bright_d;
`endif
      end
   end

   assign segments = seg_q;
   assign dp       = dp_q;
   assign ndig_en  = en_q;
   assign frame    = frame_q;
endmodule

// File: tb/tb_seg7_scan_ndig.sv
// tb_seg7_scan_ndig: directed plus randomized bench against a frame-arithmetic reference model
module tb_seg7_scan_ndig;
   localparam int NDIG = 4;
   localparam int DB   = 5;
   localparam int SLOT = 1 << DB;
   localparam int FRM  = SLOT * NDIG;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [15:0] digits = '0;
   logic [3:0]  dp_in = '0;
   logic        load = 1'b0, blank_lz = 1'b0;
   logic [6:0]  segments;
   logic        dp;
   logic [3:0]  ndig_en;
   logic        frame;
`ifdef SEG7_DIM_EN
   logic [3:0]  bright = 4'd8;
   int          bb = 0;
`endif

   int          cmp = 0, bad = 0, t = 0;
   logic [15:0] act = '0, pend = '0;
   logic [3:0]  act_dp = '0, pend_dp = '0;
   logic        pv = 1'b0, bslot = 1'b0;

   always #5 clk = ~clk;

   seg7_scan_ndig #(.NDIG(NDIG), .DIV_BITS(DB)) dut (
      .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .load(load),
      .blank_lz(blank_lz),
`ifdef SEG7_DIM_EN
      .brightness(bright),
`endif
      .segments(segments), .dp(dp), .ndig_en(ndig_en), .frame(frame));

   function automatic logic [6:0] font(input logic [3:0] n);
      case (n)
         4'h0: font = 7'b0000001; 4'h1: font = 7'b1001111;
         4'h2: font = 7'b0010010; 4'h3: font = 7'b0000110;
         4'h4: font = 7'b1001100; 4'h5: font = 7'b0100100;
         4'h6: font = 7'b0100000; 4'h7: font = 7'b0001111;
         4'h8: font = 7'b0000000; 4'h9: font = 7'b0000100;
         4'hA: font = 7'b0001000; 4'hB: font = 7'b1100000;
         4'hC: font = 7'b0110001; 4'hD: font = 7'b1000010;
         4'hE: font = 7'b0110000; default: font = 7'b0111000;
      endcase
   endfunction

   task automatic chk();
      int          presc, idx;
      logic [15:0] hi;
      logic [6:0]  e_seg;
      logic [3:0]  e_en;
      logic        e_dp, e_fr, lit;
      presc = t % SLOT;
      idx   = (t / SLOT) % NDIG;
      hi    = act >> (4 * idx);
      lit   = presc != 0;
`ifdef SEG7_DIM_EN
      lit   = lit && ((presc >> 1) < bb);
`endif
      e_en  = lit ? ~(4'b0001 << idx) : 4'b1111;
      e_seg = (t == 0 || (bslot && idx != 0 && hi == 16'h0)) ? 7'h7F : font(hi[3:0]);
      e_dp  = (t == 0) ? 1'b1 : ~act_dp[idx];
      e_fr  = (t > 0) && (t % FRM == 0);
      cmp += 4;
      assert (segments === e_seg) else begin bad++; $error("FAIL seg t=%0d got %b exp %b", t, segments, e_seg); end
      assert (dp === e_dp) else begin bad++; $error("FAIL dp t=%0d got %b exp %b", t, dp, e_dp); end
      assert (ndig_en === e_en) else begin bad++; $error("FAIL en t=%0d got %b exp %b", t, ndig_en, e_en); end
      assert (frame === e_fr) else begin bad++; $error("FAIL frame t=%0d got %b exp %b", t, frame, e_fr); end
   endtask

   // One clock: model the edge using the pre-edge cycle count, then compare.
   task automatic cyc();
      @(posedge clk);
      if (t % FRM == FRM - 1 && pv) begin act = pend; act_dp = pend_dp; pv = 1'b0; end
      if (t % SLOT == SLOT - 1) begin
         bslot = blank_lz;
`ifdef SEG7_DIM_EN
         bb = int'(bright);
`endif
      end
      if (load) begin pend = digits; pend_dp = dp_in; pv = 1'b1; end
      t++;
      #1 chk();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic pulse(input logic [15:0] d, input logic [3:0] p);
      digits = d; dp_in = p; load = 1'b1;
      cyc();
      load = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      cmp += 4;
      assert (segments === 7'h7F) else begin bad++; $error("FAIL %s seg got %h exp 7f", tag, segments); end
      assert (dp === 1'b1) else begin bad++; $error("FAIL %s dp got %b exp 1", tag, dp); end
      assert (ndig_en === 4'hF) else begin bad++; $error("FAIL %s en got %b exp 1111", tag, ndig_en); end
      assert (frame === 1'b0) else begin bad++; $error("FAIL %s frame got %b exp 0", tag, frame); end
   endtask

   task automatic model_reset();
      t = 0; act = '0; pend = '0; act_dp = '0; pend_dp = '0; pv = 1'b0; bslot = 1'b0;
`ifdef SEG7_DIM_EN
      bb = 0;
`endif
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 chk_reset("reset");
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      run(200);
      pulse(16'h12AF, 4'b0100);
      run(3 * FRM);
      blank_lz = 1'b1;
      pulse(16'h0070, 4'b0000);
      run(2 * FRM);
      pulse(16'h0000, 4'b0010);
      run(2 * FRM);
      blank_lz = 1'b0;
      while (t % FRM != 10) cyc();
      pulse(16'h1111, 4'b0001);
      run(20);
      pulse(16'h2222, 4'b0010);
      while (t % FRM != FRM - 1) cyc();
      pulse(16'h3333, 4'b1000);
      run(2 * FRM + 5);
      for (int i = 0; i < 2500; i++) begin
         load = ($urandom % 24) == 0;
         if (load) begin
            digits = 16'($urandom >> ($urandom % 17));
            dp_in  = 4'($urandom);
         end
         if ($urandom % 150 == 0) blank_lz = ~blank_lz;
`ifdef SEG7_DIM_EN
         if ($urandom % 200 == 0) bright = 4'($urandom);
`endif
         cyc();
      end
      load = 1'b0;
      pulse(16'hBEEF, 4'b1111);
      while (t % SLOT != 13) cyc();
      #3 rst_n = 1'b0;
      #1 chk_reset("async_rst");
      @(posedge clk);
      #1 chk_reset("rst_hold");
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      run(FRM + 50);
      blank_lz = 1'b1;
      pulse(16'h0305, 4'b0100);
      run(2 * FRM);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end
endmodule
